// File: rtl/io_port_buffer.sv
// rtl/io_port_buffer.sv - byte FIFO between an IO device and a DMA engine with a DMA request FSM
// Optional sticky err output is enabled by defining IO_BUF_ERR_FLAG_EN.
module io_port_buffer #(
  parameter int DEPTH      = 8,
  parameter int WREQ_LEVEL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] indata,
  input  logic       rd,
  output logic [7:0] outdata,
  output logic       io_full,
  output logic       io_empty,
  output logic       wreq
`ifdef IO_BUF_ERR_FLAG_EN
  ,
  output logic       err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] REQ_CNT  = CW'(WREQ_LEVEL);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_outdata;
  logic          r_full, r_empty, r_wreq;
  state_t        r_state;

  logic          w_wr_acc, w_rd_acc;
  logic [CW-1:0] w_count_nxt;
  state_t        w_state_nxt;

  // A full FIFO still takes a write when a read frees the head slot on the same edge.
  assign w_rd_acc = rd && !r_empty;
  assign w_wr_acc = wr && (!r_full || w_rd_acc);

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc)      w_count_nxt = r_count + CW'(1);
    else if (!w_wr_acc && w_rd_acc) w_count_nxt = r_count - CW'(1);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_count_nxt >= REQ_CNT) w_state_nxt = S_REQ;
      S_REQ:   if (w_rd_acc) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_count_nxt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= indata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_outdata <= 8'h00;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_wreq    <= 1'b0;
      r_state   <= S_IDLE;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
      if (w_rd_acc) begin
        r_rptr    <= r_rptr + AW'(1);
        r_outdata <= r_mem[r_rptr];
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == '0);
      r_state <= w_state_nxt;
      r_wreq  <= (w_state_nxt != S_IDLE);
    end
  end

`ifdef IO_BUF_ERR_FLAG_EN
  logic r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else if ((wr && !w_wr_acc) || (rd && r_empty)) r_err <= 1'b1;
  end
  assign err = r_err;
`endif

  assign outdata  = r_outdata;
  assign io_full  = r_full;
  assign io_empty = r_empty;
  assign wreq     = r_wreq;

endmodule

// File: tb/tb_io_port_buffer.sv
// tb/tb_io_port_buffer.sv - scoreboard bench for io_port_buffer (DEPTH=8, WREQ_LEVEL=4)
module tb_io_port_buffer;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst, wr, rd;
  logic [7:0] indata, outdata;
  logic io_full, io_empty, wreq;
`ifdef IO_BUF_ERR_FLAG_EN
  logic err;
  logic m_err;
`endif

  int total = 0;
  int bad = 0;
  logic [7:0] sb[$];
  logic       last_pop;
  logic [7:0] last_exp, m_out;

  always #5 clk = ~clk;

  io_port_buffer #(.DEPTH(DEPTH), .WREQ_LEVEL(4)) dut (
    .clk(clk), .rst(rst), .wr(wr), .indata(indata), .rd(rd),
    .outdata(outdata), .io_full(io_full), .io_empty(io_empty), .wreq(wreq)
`ifdef IO_BUF_ERR_FLAG_EN
    , .err(err)
`endif
  );

  // One clock of stimulus; the reference model decides acceptance and queues expected bytes.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    logic wacc, racc;
    racc = r && (sb.size() != 0);
    wacc = w && ((sb.size() < DEPTH) || racc);
    last_pop = racc;
    if (racc) begin last_exp = sb.pop_front(); m_out = last_exp; end
    if (wacc) sb.push_back(d);
`ifdef IO_BUF_ERR_FLAG_EN
    if ((w && !wacc) || (r && !racc)) m_err = 1'b1;
`endif
    wr = w; indata = d; rd = r;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; indata = 8'h00;
    sb.delete(); m_out = 8'h00; last_exp = 8'h00;
`ifdef IO_BUF_ERR_FLAG_EN
    m_err = 1'b0;
`endif
    repeat (2) @(posedge clk); #1;
    total++; if (outdata !== 8'h00) begin bad++; $display("FAIL reset_outdata got=%h exp=00", outdata); end
    total++; if (io_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", io_empty); end
    total++; if (io_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", io_full); end
    total++; if (wreq !== 1'b0) begin bad++; $display("FAIL reset_wreq got=%b exp=0", wreq); end
`ifdef IO_BUF_ERR_FLAG_EN
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic;
    for (int i = 0; i < 4; i++) begin
      total++; if (wreq !== 1'b0) begin bad++; $display("FAIL basic_wreq_early i=%0d got=%b exp=0", i, wreq); end
      step(1'b1, 8'hA1 + 8'(i), 1'b0);
    end
    total++; if (wreq !== 1'b1) begin bad++; $display("FAIL basic_wreq got=%b exp=1", wreq); end
    total++; if (io_empty !== 1'b0) begin bad++; $display("FAIL basic_empty got=%b exp=0", io_empty); end
    total++; if (io_full !== 1'b0) begin bad++; $display("FAIL basic_full got=%b exp=0", io_full); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++; if (outdata !== last_exp) begin bad++; $display("FAIL basic_read i=%0d got=%h exp=%h", i, outdata, last_exp); end
    end
    total++; if (io_empty !== 1'b1) begin bad++; $display("FAIL basic_empty_end got=%b exp=1", io_empty); end
    total++; if (wreq !== 1'b0) begin bad++; $display("FAIL basic_wreq_end got=%b exp=0", wreq); end
  endtask

  task automatic test_full;
    for (int i = 0; i < 8; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
    total++; if (io_full !== 1'b1) begin bad++; $display("FAIL full_flag got=%b exp=1", io_full); end
    step(1'b1, 8'hFF, 1'b0);
    total++; if (io_full !== 1'b1) begin bad++; $display("FAIL full_drop_flag got=%b exp=1", io_full); end
    total++; if (outdata !== m_out) begin bad++; $display("FAIL full_drop_out got=%h exp=%h", outdata, m_out); end
`ifdef IO_BUF_ERR_FLAG_EN
    total++; if (err !== m_err) begin bad++; $display("FAIL full_err got=%b exp=%b", err, m_err); end
`endif
    step(1'b1, 8'h55, 1'b1);
    total++; if (outdata !== 8'h10) begin bad++; $display("FAIL full_rw_out got=%h exp=10", outdata); end
    total++; if (io_full !== 1'b1) begin bad++; $display("FAIL full_rw_flag got=%b exp=1", io_full); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++; if (outdata !== last_exp) begin bad++; $display("FAIL full_read i=%0d got=%h exp=%h", i, outdata, last_exp); end
    end
    total++; if (last_exp !== 8'h55) begin bad++; $display("FAIL full_last_byte got=%h exp=55", last_exp); end
    total++; if (io_empty !== 1'b1) begin bad++; $display("FAIL full_empty_end got=%b exp=1", io_empty); end
    step(1'b0, 8'h00, 1'b1);
    total++; if (outdata !== 8'h55) begin bad++; $display("FAIL empty_read_hold got=%h exp=55", outdata); end
    step(1'b1, 8'h66, 1'b1);
    total++; if (outdata !== 8'h55) begin bad++; $display("FAIL empty_rw_hold got=%h exp=55", outdata); end
    total++; if (io_empty !== 1'b0) begin bad++; $display("FAIL empty_rw_flag got=%b exp=0", io_empty); end
    step(1'b0, 8'h00, 1'b1);
    total++; if (outdata !== 8'h66) begin bad++; $display("FAIL empty_rw_read got=%h exp=66", outdata); end
`ifdef IO_BUF_ERR_FLAG_EN
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
`endif
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 6; i++) step(1'b1, 8'h20 + 8'(i), 1'b0);
    total++; if (wreq !== 1'b1) begin bad++; $display("FAIL wrap_wreq got=%b exp=1", wreq); end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++; if (outdata !== last_exp) begin bad++; $display("FAIL wrap_read_a i=%0d got=%h exp=%h", i, outdata, last_exp); end
    end
    for (int i = 0; i < 6; i++) step(1'b1, 8'h30 + 8'(i), 1'b0);
    total++; if (io_full !== 1'b1) begin bad++; $display("FAIL wrap_full got=%b exp=1", io_full); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++; if (outdata !== last_exp) begin bad++; $display("FAIL wrap_read_b i=%0d got=%h exp=%h", i, outdata, last_exp); end
      total++; if (wreq !== (i < 7)) begin bad++; $display("FAIL wrap_drain_wreq i=%0d got=%b exp=%b", i, wreq, (i < 7)); end
    end
    for (int i = 0; i < 4; i++) step(1'b1, 8'h40 + 8'(i), 1'b0);
    total++; if (wreq !== 1'b1) begin bad++; $display("FAIL wrap_rereq got=%b exp=1", wreq); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++; if (outdata !== last_exp) begin bad++; $display("FAIL wrap_read_c i=%0d got=%h exp=%h", i, outdata, last_exp); end
    end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 5; i++) step(1'b1, 8'h70 + 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    total++; if (wreq !== 1'b1) begin bad++; $display("FAIL arst_pre_wreq got=%b exp=1", wreq); end
    rst = 1'b1;
    #1;
    sb.delete(); m_out = 8'h00;
`ifdef IO_BUF_ERR_FLAG_EN
    m_err = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL arst_err got=%b exp=0", err); end
`endif
    total++; if (outdata !== 8'h00) begin bad++; $display("FAIL arst_outdata got=%h exp=00", outdata); end
    total++; if (io_empty !== 1'b1) begin bad++; $display("FAIL arst_empty got=%b exp=1", io_empty); end
    total++; if (io_full !== 1'b0) begin bad++; $display("FAIL arst_full got=%b exp=0", io_full); end
    total++; if (wreq !== 1'b0) begin bad++; $display("FAIL arst_wreq got=%b exp=0", wreq); end
    #1 rst = 1'b0;
    step(1'b0, 8'h00, 1'b1);
    total++; if (outdata !== 8'h00) begin bad++; $display("FAIL arst_rd_hold got=%h exp=00", outdata); end
    step(1'b1, 8'h77, 1'b0);
    total++; if (io_empty !== 1'b0) begin bad++; $display("FAIL arst_first_wr got=%b exp=0", io_empty); end
    step(1'b0, 8'h00, 1'b1);
    total++; if (outdata !== 8'h77) begin bad++; $display("FAIL arst_first_rd got=%h exp=77", outdata); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_reset();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
